hysteresis_tracking: RTL and testbench

- Downstream of edge_detection; consumes its 2-bit per-pixel classification stream (raster order) and applies Canny double-threshold hysteresis over a 3x3 neighbourhood.
- Emits one binary edge bit per interior pixel for the output writer.
- Input frame is WIDTH x HEIGHT (504x504 by default, matching the edge_detection output); output frame is (WIDTH-2) x (HEIGHT-2).

---
 rtl/hysteresis_tracking.sv | 117 +++++++++++
 tb/tb_hysteresis_tracking.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/hysteresis_tracking.sv
// Canny double-threshold hysteresis over a 3x3 window on a raster stream of 2-bit pixel classes.
// Optional HYST_EDGE_COUNT_EN adds a per-frame edge_count output.
module hysteresis_tracking #(
  parameter int WIDTH    = 504,
  parameter int HEIGHT   = 504,
  parameter int COL_BITS = 9,
  parameter int ROW_BITS = 9
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  input  logic [1:0]          in_pixel,
  output logic                out_valid,
  output logic                out_edge,
  output logic [ROW_BITS-1:0] out_row,
  output logic [COL_BITS-1:0] out_col,
`ifdef HYST_EDGE_COUNT_EN
  output logic [19:0]         edge_count,
`endif
  output logic                frame_done
);

  logic [1:0] line1 [WIDTH];   // row r-1
  logic [1:0] line2 [WIDTH];   // row r-2

  logic [COL_BITS-1:0] col;
  logic [ROW_BITS-1:0] row;

  // win[i][j]: i=0 oldest row (r-2) .. 2 current row; j=0 leftmost column .. 2 newest.
  logic [2:0][2:0][1:0] win, win_next;
  logic [1:0]           centre;
  logic                 strong_nb, edge_next, emit, last_col, last_row;

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    win_next = win;
    for (int i = 0; i < 3; i++) begin
      win_next[i][0] = win[i][1];
      win_next[i][1] = win[i][2];
    end
    win_next[0][2] = line2[col];
    win_next[1][2] = line1[col];
    win_next[2][2] = in_pixel;

    centre    = win_next[1][1];
    strong_nb = 1'b0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        if (!(i == 1 && j == 1) && win_next[i][j][1]) strong_nb = 1'b1;
    edge_next = centre[1] | ((centre == 2'b01) & strong_nb);
  end

  assign last_col = (col == COL_BITS'(WIDTH - 1));
  assign last_row = (row == ROW_BITS'(HEIGHT - 1));
  assign emit     = in_valid && (row >= ROW_BITS'(2)) && (col >= COL_BITS'(2));

  // NOTE: line buffers carry no reset; rows 0 and 1 of every frame overwrite them before any
  // window built from them is emitted, so stale contents are harmless.
  always_ff @(posedge clk) begin
    if (in_valid) begin
      line2[col] <= line1[col];
      line1[col] <= in_pixel;
    end
  end

`ifdef HYST_EDGE_COUNT_EN
  logic [19:0] edge_cnt, cnt_next;
  assign cnt_next = edge_cnt + {19'd0, edge_next};
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col        <= '0;
      row        <= '0;
      win        <= '0;
      out_valid  <= 1'b0;
      out_edge   <= 1'b0;
      out_row    <= '0;
      out_col    <= '0;
      frame_done <= 1'b0;
`ifdef HYST_EDGE_COUNT_EN
      edge_cnt   <= '0;
      edge_count <= '0;
`endif
    end else begin
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (in_valid) begin
        win <= win_next;
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (emit) begin
          out_valid  <= 1'b1;
          out_edge   <= edge_next;
          out_row    <= row - ROW_BITS'(2);
          out_col    <= col - COL_BITS'(2);
          frame_done <= last_row && last_col;
`ifdef HYST_EDGE_COUNT_EN
          // Final total includes the frame's last pixel, then the running count restarts.
          if (last_row && last_col) begin
            edge_count <= cnt_next;
            edge_cnt   <= '0;
          end else begin
            edge_cnt   <= cnt_next;
          end
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_hysteresis_tracking.sv
// Scoreboard bench for hysteresis_tracking on a 5x5 frame; also checks edge_count when
// HYST_EDGE_COUNT_EN is defined.
module tb_hysteresis_tracking;
  localparam int W = 5;
  localparam int H = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_pixel = 2'b00;
  logic       out_valid, out_edge, frame_done;
  logic [8:0] out_row, out_col;
`ifdef HYST_EDGE_COUNT_EN
  logic [19:0] edge_count;
`endif

  hysteresis_tracking #(.WIDTH(W), .HEIGHT(H), .COL_BITS(9), .ROW_BITS(9)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .out_valid  (out_valid),
    .out_edge   (out_edge),
    .out_row    (out_row),
    .out_col    (out_col),
`ifdef HYST_EDGE_COUNT_EN
    .edge_count (edge_count),
`endif
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    int row;
    int col;
    bit edg;
    bit done;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   n_out, n_done, acc;
  bit [1:0] img [H][W];
  int   got [H-2][W-2];
  int   ref_got [H-2][W-2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: centre strong, or centre weak with any strong 8-neighbour.
  function automatic bit model(int r, int c);
    if (img[r][c][1]) return 1'b1;
    if (img[r][c] != 2'b01) return 1'b0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        if (!(dr == 0 && dc == 0) && img[r+dr][c+dc][1]) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (rst_n) begin
      while (q.size() > 0 && q[0].due < cyc) begin
        check("missing_out", 0, 1);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_t e;
        e = q.pop_front();
        check("out_valid", out_valid, 1);
        check("out_row", out_row, e.row);
        check("out_col", out_col, e.col);
        check("out_edge", out_edge, e.edg);
        check("frame_done", frame_done, e.done);
        got[e.row][e.col] = out_edge;
        n_out++;
        if (frame_done) n_done++;
        acc += int'(e.edg);
`ifdef HYST_EDGE_COUNT_EN
        if (e.done) begin
          check("edge_count", edge_count, acc);
          acc = 0;
        end
`endif
      end else begin
        if (out_valid)  check("spurious_valid", out_valid, 0);
        if (frame_done) check("spurious_done", frame_done, 0);
      end
    end
  end

  task automatic send(input int gap, input int npix);
    int k = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        if (k < npix) begin
          @(negedge clk); #1;
          in_valid = 1'b1;
          in_pixel = img[r][c];
          if (r >= 2 && c >= 2)
            q.push_back('{cyc + 1, r - 2, c - 2, model(r - 1, c - 1), (r == H-1 && c == W-1)});
          for (int g = 0; g < gap; g++) begin
            @(negedge clk); #1;
            in_valid = 1'b0;
            in_pixel = 2'($urandom_range(0, 3));
          end
        end
        k++;
      end
    @(negedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int gap);
    for (int r = 0; r < H-2; r++)
      for (int c = 0; c < W-2; c++) got[r][c] = 2;
    n_out  = 0;
    n_done = 0;
    send(gap, W*H);
    repeat (3) @(negedge clk);
    check("n_out", n_out, 9);
    check("n_done", n_done, 1);
  endtask

  function automatic int edges_total();
    int s = 0;
    for (int r = 0; r < H-2; r++)
      for (int c = 0; c < W-2; c++) s += got[r][c];
    return s;
  endfunction

  task automatic clear_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 2'b00;
  endtask

  task automatic rand_img();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) img[r][c] = 2'($urandom_range(0, 3));
  endtask

  task automatic pulse_reset();
    @(negedge clk); #1;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    q.delete();
    acc = 0;
    @(negedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    acc = 0;
    // Reset held with random activity on the inputs.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rst_valid", out_valid, 0);
      check("rst_edge", out_edge, 0);
      check("rst_row", out_row, 0);
      check("rst_col", out_col, 0);
      check("rst_done", frame_done, 0);
`ifdef HYST_EDGE_COUNT_EN
      check("rst_count", edge_count, 0);
`endif
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_pixel = 2'($urandom_range(0, 3));
    end
    #1;
    in_valid = 1'b0;
    rst_n    = 1'b1;

    clear_img();
    run_frame(0);
    check("zero_total", edges_total(), 0);

    // Weak centre with strong neighbour; strong pixel is itself an edge.
    clear_img();
    img[2][2] = 2'b01;
    img[1][1] = 2'b10;
    run_frame(0);
    check("weak_strong_11", got[1][1], 1);
    check("strong_00", got[0][0], 1);
    check("weak_strong_total", edges_total(), 2);
    img[1][1] = 2'b00;
    img[4][4] = 2'b10;
    run_frame(0);
    check("weak_far_11", got[1][1], 0);
    check("weak_far_total", edges_total(), 0);

    // Code 11 counts as strong; isolated weak pixels stay off.
    clear_img();
    img[3][3] = 2'b11;
    run_frame(0);
    check("code11_22", got[2][2], 1);
    check("code11_total", edges_total(), 1);
    img[3][3] = 2'b10;
    img[1][1] = 2'b01;
    img[1][3] = 2'b01;
    run_frame(0);
    check("code10_22", got[2][2], 1);
    check("code10_total", edges_total(), 1);

    // Sparse input must give the same decisions as dense input.
    rand_img();
    run_frame(0);
    ref_got = got;
    run_frame(1);
    for (int r = 0; r < H-2; r++)
      for (int c = 0; c < W-2; c++) check("sparse_eq", got[r][c], ref_got[r][c]);

    // Reset mid-frame, then two back-to-back full frames.
    rand_img();
    send(0, 12);
    pulse_reset();
    rand_img();
    run_frame(0);
    ref_got = got;
    run_frame(0);
    for (int r = 0; r < H-2; r++)
      for (int c = 0; c < W-2; c++) check("b2b_eq", got[r][c], ref_got[r][c]);

    repeat (2) @(negedge clk);
    check("queue_empty", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
